// File: rtl/banded_sw_accelerator.sv
// Banded Smith-Waterman aligner for two 8-base DNA sequences: fills the scoring band,
// traces back from the best cell and presents the gapped alignment in forward order.
module banded_sw_accelerator (
  input  logic        clk,
  input  logic        start,
  input  logic [23:0] R,
  input  logic [23:0] Q,
  output logic [29:0] R_aligned,
  output logic [29:0] Q_aligned,
  output logic        ready
);
  localparam int unsigned LEN    = 8;
  localparam int unsigned BAND   = 2;
  localparam int unsigned MAXCOL = 10;
  localparam int unsigned SYM_W  = 3;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned SC_W   = 6;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned OUT_W  = MAXCOL * SYM_W;

  localparam logic signed [SC_W-1:0] MATCH    = 6'sd2;
  localparam logic signed [SC_W-1:0] MISMATCH = -6'sd1;
  localparam logic signed [SC_W-1:0] GAP      = -6'sd1;
  localparam logic [SYM_W-1:0]       GAP_SYM  = 3'b111;

  typedef enum logic [2:0] {IDLE, LOAD, FILL, TRACE, DONE} state_t;

  state_t                 state;
  logic signed [SC_W-1:0] h [0:LEN][0:LEN];
  logic [SYM_W-1:0]       r_b [0:LEN];
  logic [SYM_W-1:0]       q_b [0:LEN];
  logic [IDX_W-1:0]       fi, fj, ti, tj, bi, bj;
  logic signed [SC_W-1:0] best;
  logic [CNT_W-1:0]       ncol;
  logic [OUT_W-1:0]       r_buf, q_buf;

  logic signed [SC_W-1:0] cell_c, cur_c, tdiag_c, tup_c;
  logic signed [SC_W-1:0] fdiag_c, fup_c, fleft_c;
  logic                   take_best_c;

  function automatic logic signed [SC_W-1:0] subst(input logic [SYM_W-1:0] a,
                                                    input logic [SYM_W-1:0] b);
    // Only real bases (A,C,G,T) can match; pad and illegal codes always mismatch
    subst = ((a == b) && (a != '0) && (a <= 3'd4)) ? MATCH : MISMATCH;
  endfunction

  function automatic logic [IDX_W-1:0] dec(input logic [IDX_W-1:0] x);
    dec = (x == '0) ? '0 : x - IDX_W'(1);
  endfunction

  function automatic logic [IDX_W-1:0] row_first(input logic [IDX_W-1:0] i);
    row_first = (i > IDX_W'(BAND)) ? i - IDX_W'(BAND) : IDX_W'(1);
  endfunction

  function automatic logic [IDX_W-1:0] row_last(input logic [IDX_W-1:0] i);
    row_last = (i < IDX_W'(LEN - BAND)) ? i + IDX_W'(BAND) : IDX_W'(LEN);
  endfunction

  // Cell score for the fill position and predecessor candidates for the trace position
  always_comb begin
    cell_c      = '0;
    fdiag_c     = h[dec(fi)][dec(fj)] + subst(r_b[fi], q_b[fj]);
    fup_c       = h[dec(fi)][fj] + GAP;
    fleft_c     = h[fi][dec(fj)] + GAP;
    if (fdiag_c > cell_c) cell_c = fdiag_c;
    if (fup_c   > cell_c) cell_c = fup_c;
    if (fleft_c > cell_c) cell_c = fleft_c;
    take_best_c = (cell_c > best);
    cur_c       = h[ti][tj];
    tdiag_c     = h[dec(ti)][dec(tj)] + subst(r_b[ti], q_b[tj]);
    tup_c       = h[dec(ti)][tj] + GAP;
  end

  always_ff @(posedge clk) begin
    if (start) begin
      state     <= IDLE;
      ready     <= 1'b0;
      R_aligned <= '0;
      Q_aligned <= '0;
      fi        <= '0;
      fj        <= '0;
      ti        <= '0;
      tj        <= '0;
      bi        <= '0;
      bj        <= '0;
      best      <= '0;
      ncol      <= '0;
      r_buf     <= '0;
      q_buf     <= '0;
      for (int a = 0; a <= LEN; a++) begin
        r_b[a] <= '0;
        q_b[a] <= '0;
        for (int b = 0; b <= LEN; b++) h[a][b] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          for (int k = 1; k <= LEN; k++) begin
            r_b[k] <= R[(LEN-k)*SYM_W +: SYM_W];
            q_b[k] <= Q[(LEN-k)*SYM_W +: SYM_W];
          end
          state <= LOAD;
        end
        LOAD: begin
          fi    <= IDX_W'(1);
          fj    <= IDX_W'(1);
          bi    <= IDX_W'(1);
          bj    <= IDX_W'(1);
          best  <= '0;
          ncol  <= '0;
          r_buf <= '0;
          q_buf <= '0;
          state <= FILL;
        end
        FILL: begin
          h[fi][fj] <= cell_c;
          if (take_best_c) begin
            best <= cell_c;
            bi   <= fi;
            bj   <= fj;
          end
          if (fj == row_last(fi)) begin
            if (fi == IDX_W'(LEN)) begin
              ti    <= take_best_c ? fi : bi;
              tj    <= take_best_c ? fj : bj;
              state <= TRACE;
            end else begin
              fi <= fi + IDX_W'(1);
              fj <= row_first(fi + IDX_W'(1));
            end
          end else begin
            fj <= fj + IDX_W'(1);
          end
        end
        TRACE: begin
          if ((cur_c == '0) || (ncol == CNT_W'(MAXCOL))) begin
            R_aligned <= r_buf;
            Q_aligned <= q_buf;
            ready     <= 1'b1;
            state     <= DONE;
          end else begin
            // Columns arrive last-first, so shifting in at the top leaves them in forward order
            ncol <= ncol + CNT_W'(1);
            if (cur_c == tdiag_c) begin
              r_buf <= {r_b[ti], r_buf[OUT_W-1:SYM_W]};
              q_buf <= {q_b[tj], q_buf[OUT_W-1:SYM_W]};
              ti    <= dec(ti);
              tj    <= dec(tj);
            end else if (cur_c == tup_c) begin
              r_buf <= {r_b[ti], r_buf[OUT_W-1:SYM_W]};
              q_buf <= {GAP_SYM, q_buf[OUT_W-1:SYM_W]};
              ti    <= dec(ti);
            end else begin
              r_buf <= {GAP_SYM, r_buf[OUT_W-1:SYM_W]};
              q_buf <= {q_b[tj], q_buf[OUT_W-1:SYM_W]};
              tj    <= dec(tj);
            end
          end
        end
        DONE: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_banded_sw_accelerator.sv
// Self-checking bench for banded_sw_accelerator: fixed vectors, randomized runs against a
// whole-matrix alignment model, and reset/abort/input-stability sequences.
module tb_banded_sw_accelerator;
  logic        clk;
  logic        start;
  logic [23:0] R, Q;
  logic [29:0] R_aligned, Q_aligned;
  logic        ready;

  int n_tests = 0;
  int n_fail  = 0;

  banded_sw_accelerator dut (
    .clk(clk), .start(start), .R(R), .Q(Q),
    .R_aligned(R_aligned), .Q_aligned(Q_aligned), .ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [23:0] r;
    logic [23:0] q;
    logic [29:0] er;
    logic [29:0] eq;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [2:0] base_of(input logic [23:0] s, input int k);
    return s[(8-k)*3 +: 3];
  endfunction

  function automatic int score(input logic [2:0] a, input logic [2:0] b);
    return (a == b && a >= 3'd1 && a <= 3'd4) ? 2 : -1;
  endfunction

  // Reference: full matrix with out-of-band cells left at 0, then traceback into queues
  function automatic void ref_align(input logic [23:0] r, input logic [23:0] q,
                                    output logic [29:0] ra, output logic [29:0] qa);
    int h [0:8][0:8];
    int best, bi, bj, i, j;
    logic [2:0] rq[$];
    logic [2:0] qq[$];
    for (int a = 0; a <= 8; a++)
      for (int b = 0; b <= 8; b++) h[a][b] = 0;
    best = 0; bi = 1; bj = 1;
    for (int a = 1; a <= 8; a++) begin
      for (int b = 1; b <= 8; b++) begin
        if (a - b <= 2 && b - a <= 2) begin
          int v;
          v = 0;
          if (h[a-1][b-1] + score(base_of(r, a), base_of(q, b)) > v)
            v = h[a-1][b-1] + score(base_of(r, a), base_of(q, b));
          if (h[a-1][b] - 1 > v) v = h[a-1][b] - 1;
          if (h[a][b-1] - 1 > v) v = h[a][b-1] - 1;
          h[a][b] = v;
          if (v > best) begin best = v; bi = a; bj = b; end
        end
      end
    end
    i = bi; j = bj;
    while (h[i][j] > 0 && rq.size() < 10) begin
      if (h[i][j] == h[i-1][j-1] + score(base_of(r, i), base_of(q, j))) begin
        rq.push_front(base_of(r, i)); qq.push_front(base_of(q, j)); i--; j--;
      end else if (h[i][j] == h[i-1][j] - 1) begin
        rq.push_front(base_of(r, i)); qq.push_front(3'b111); i--;
      end else begin
        rq.push_front(3'b111); qq.push_front(base_of(q, j)); j--;
      end
    end
    ra = '0; qa = '0;
    for (int k = 0; k < rq.size(); k++) begin
      ra[29-3*k -: 3] = rq[k];
      qa[29-3*k -: 3] = qq[k];
    end
  endfunction

  task automatic launch(input logic [23:0] r, input logic [23:0] q);
    @(negedge clk);
    start = 1'b1; R = r; Q = q;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); #1;
      if (ready) break;
    end
    check({name, "_ready"}, 32'(ready), 32'd1);
  endtask

  function automatic logic [2:0] rand_base(input int alpha);
    int x;
    if ($urandom_range(0, 11) == 0) begin
      x = $urandom_range(0, 3);
      return (x == 0) ? 3'd0 : 3'(x + 4);
    end
    return 3'($urandom_range(1, alpha));
  endfunction

  task automatic rand_pair(output logic [23:0] r, output logic [23:0] q);
    logic [2:0] rb [1:9];
    logic [2:0] qb [1:8];
    int alpha, mode, p;
    alpha = ($urandom_range(0, 1) == 0) ? 2 : 4;
    mode  = $urandom_range(0, 3);
    p     = $urandom_range(1, 8);
    for (int k = 1; k <= 9; k++) rb[k] = rand_base(alpha);
    for (int k = 1; k <= 8; k++) begin
      case (mode)
        0: qb[k] = rand_base(alpha);
        1: qb[k] = ($urandom_range(0, 4) == 0) ? rand_base(alpha) : rb[k];
        2: qb[k] = (k < p) ? rb[k] : rb[k+1];
        default: qb[k] = (k < p) ? rb[k] : ((k == p) ? rand_base(alpha) : rb[k-1]);
      endcase
    end
    for (int k = 1; k <= 8; k++) begin
      r[(8-k)*3 +: 3] = rb[k];
      q[(8-k)*3 +: 3] = qb[k];
    end
  endtask

  initial begin
    vec_t        vecs [7];
    logic [23:0] r, q, r2, q2;
    logic [29:0] er, eq, hr, hq;
    bit          held;

    vecs[0] = '{24'h29C29C, 24'h29C29C, 30'hA70A700, 30'hA70A700};
    vecs[1] = '{24'h249249, 24'h492492, 30'h0,       30'h0};
    vecs[2] = '{24'h29C29C, 24'h2994E1, 30'hA70A700, 30'hA7CA700};
    vecs[3] = '{24'h249249, 24'h249249, 30'h9249240, 30'h9249240};
    vecs[4] = '{24'h000000, 24'h000000, 30'h0,       30'h0};
    vecs[5] = '{24'hB6DB6D, 24'hB6DB6D, 30'h0,       30'h0};
    vecs[6] = '{24'hFFFFFF, 24'hFFFFFF, 30'h0,       30'h0};

    start = 1'b1; R = '0; Q = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_r", 32'(R_aligned), 32'd0);
    check("reset_q", 32'(Q_aligned), 32'd0);

    for (int v = 0; v < 7; v++) begin
      launch(vecs[v].r, vecs[v].q);
      wait_ready($sformatf("vec%0d", v));
      check($sformatf("vec%0d_r", v), 32'(R_aligned), 32'(vecs[v].er));
      check($sformatf("vec%0d_q", v), 32'(Q_aligned), 32'(vecs[v].eq));
    end

    // Reset after a finished non-zero result clears everything on the first edge
    launch(24'h29C29C, 24'h29C29C);
    wait_ready("prereset");
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    check("rst_edge_ready", 32'(ready), 32'd0);
    check("rst_edge_r", 32'(R_aligned), 32'd0);
    check("rst_edge_q", 32'(Q_aligned), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_ready", 32'(ready), 32'd0);

    // Abort mid-fill, then restart with new inputs
    launch(24'h249249, 24'h249249);
    repeat (12) @(posedge clk);
    @(negedge clk);
    start = 1'b1; R = 24'h29C29C; Q = 24'h2994E1;
    @(posedge clk); #1;
    check("abort_ready", 32'(ready), 32'd0);
    @(negedge clk); start = 1'b0;
    wait_ready("abort");
    check("abort_r", 32'(R_aligned), 32'h0A70A700);
    check("abort_q", 32'(Q_aligned), 32'h0A7CA700);

    // Input changes after launch are ignored; result then holds for 1000 cycles
    rand_pair(r, q);
    ref_align(r, q, er, eq);
    launch(r, q);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rand_pair(r2, q2);
    R = r2; Q = q2;
    wait_ready("stable");
    check("stable_r", 32'(R_aligned), 32'(er));
    check("stable_q", 32'(Q_aligned), 32'(eq));
    hr = R_aligned; hq = Q_aligned; held = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      R = 24'($urandom); Q = 24'($urandom);
      if (!ready || R_aligned !== hr || Q_aligned !== hq) held = 1'b0;
    end
    check("hold_1000", 32'(held), 32'd1);

    // Randomized runs against the reference model
    for (int t = 0; t < 40; t++) begin
      rand_pair(r, q);
      ref_align(r, q, er, eq);
      launch(r, q);
      wait_ready($sformatf("rnd%0d", t));
      check($sformatf("rnd%0d_r r=%h q=%h", t, r, q), 32'(R_aligned), 32'(er));
      check($sformatf("rnd%0d_q r=%h q=%h", t, r, q), 32'(Q_aligned), 32'(eq));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/banded_sw_accelerator.md
Name: banded_sw_accelerator

Overview:
Hardware block that computes a banded Smith-Waterman local alignment of two 8-base DNA sequences. R and Q are driven combinationally from a constant sequence memory (xmem). The block fills a banded scoring matrix, traces back from the best cell, and presents the gapped, aligned sequences with a ready flag.

Parameters:
- LEN, 8, bases per input sequence
- BAND, 2, band half-width; only cells with |i-j| <= BAND are computed
- MAXCOL, 10, max aligned columns output
- MATCH, 2, match score (signed)
- MISMATCH, -1, mismatch score
- GAP, -1, linear gap score

Ports:
- clk  input  1  single clock, rising edge
- start  input  1  synchronous active-high reset; also launches a new alignment when it falls
- R  input  24  reference, 8 bases x 3 bits, base 1 in [23:21]
- Q  input  24  query, same packing
- R_aligned  output  30  10 symbols x 3 bits, first column in [29:27]
- Q_aligned  output  30  same packing
- ready  output  1  high when the outputs hold a finished result

Behaviour:
- Symbol code: A=001, C=010, G=011, T=100, gap=111, unused/pad=000.
- Input codes 000 and 101 to 111 in R/Q count as mismatch against everything.
- Reset: while start=1 at a rising edge:
  - state goes to IDLE.
  - R_aligned, Q_aligned and ready go to 0.
  - All matrix and score registers clear.
- Launch: on the first rising edge with start=0 after start=1, R and Q are latched into internal registers (LOAD). Later input changes are ignored until the next start pulse.
- States: IDLE -> LOAD -> FILL -> TRACE -> DONE. DONE holds until start.
- FILL:
  - H(i,0)=H(0,j)=0.
  - Cells outside the band count as 0 for every neighbour reference.
  - H(i,j) = max(0, H(i-1,j-1)+s(R_i,Q_j), H(i-1,j)+GAP, H(i,j-1)+GAP).
  - One band cell per cycle in row-major order (34 cells).
  - Scores are 6-bit signed; saturation is not needed (max 16).
  - Track the max cell. On equal scores keep the earliest in row-major order (strictly greater replaces).
- TRACE:
  - Start at the max cell; one step per cycle.
  - Predecessor priority on ties: diagonal, then up (R base vs gap in Q), then left (gap in R vs Q base).
  - Stop when the current cell score is 0 or MAXCOL columns have been emitted. A diagonal step into a 0 cell still emits that column.
- Output formatting:
  - Columns are emitted in forward order: first aligned column in bits [29:27], remaining slots are 000 pad.
  - If the max score is 0, both outputs stay 0.
- DONE: ready=1 and outputs hold steady. ready deasserts only via start.
- ready is asserted no later than 60 cycles after start falls.
- start asserted mid-FILL or mid-TRACE:
  - Aborts the run and applies the reset values on that edge.
  - The new run latches the inputs present when start falls.
- No outputs change except on rising clk edges.

Test Plan:
- Identical sequences: R=Q=0x29C29C (ACGTACGT), pulse start -> within 60 cycles ready=1, R_aligned=Q_aligned=0xA70A700, score 16.
- No match: R=0x249249 (AAAAAAAA), Q=0x492492 (CCCCCCCC) -> ready=1, R_aligned=0, Q_aligned=0.
- Single gap: R=0x29C29C, Q=0x2994E1 (ACGACGTA) -> R_aligned=0xA70A700, Q_aligned=0xA7CA700 (ACG-ACGT), score 13.
- Reset: hold start=1 for 3 cycles after a finished run -> ready=0 and both outputs 0 on the first edge.
- Abort and restart: assert start 10 cycles into FILL, change R/Q, release -> result matches the new inputs and no stale bits.
- Input stability: change R/Q during FILL without start -> result is unchanged from the latched inputs, and ready stays 1 after DONE for 1000 cycles.
